// File: rtl/operand_regfile_pkg.sv
// Shared operand-stage definitions: widths, shift codes and operand-state encoding.
// The shifter and decoder import the shift-code constants from here as well.
package operand_regfile_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int REG_AW = 3;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    HAVE_B = 2'd2,
    READY  = 2'd3
  } opnd_state_t;

endpackage

// File: rtl/operand_regfile_regfile_core.sv
// Register array with one synchronous write port and two combinational read ports.
// OPERAND_REGFILE_BYPASS_EN forwards same-cycle write data onto a matching read port.
module regfile_core
  import operand_regfile_pkg::*;
#(
  parameter int DATA_W = operand_regfile_pkg::DATA_W,
  parameter int NREGS  = operand_regfile_pkg::NREGS,
  parameter int REG_AW = operand_regfile_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [REG_AW-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic [REG_AW-1:0] readnum_a,
  input  logic [REG_AW-1:0] readnum_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  always_comb begin
    rdata_a = regs[readnum_a];
    rdata_b = regs[readnum_b];
`ifdef OPERAND_REGFILE_BYPASS_EN
    // Each port forwards independently so A and B may both see the new value.
    if (write && (readnum_a == writenum)) rdata_a = data_in;
    if (write && (readnum_b == writenum)) rdata_b = data_in;
`endif
  end

endmodule

// File: rtl/operand_regfile.sv
// Operand stage feeding the shifter/ALU: latches A and B (+shift code) one cycle after load.
// Readiness FSM; issue while not ready is ignored and flagged. Build option: OPERAND_REGFILE_BYPASS_EN.
module operand_regfile
  import operand_regfile_pkg::*;
#(
  parameter int DATA_W = operand_regfile_pkg::DATA_W,
  parameter int NREGS  = operand_regfile_pkg::NREGS,
  parameter int REG_AW = operand_regfile_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [REG_AW-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic [REG_AW-1:0] readnum_a,
  input  logic [REG_AW-1:0] readnum_b,
  input  logic              loada,
  input  logic              loadb,
  input  logic [1:0]        shift_in,
  input  logic              issue,
  output logic [DATA_W-1:0] aout,
  output logic [DATA_W-1:0] bout,
  output logic [1:0]        shift_out,
  output logic              opnd_rdy,
  output logic              issue_err
);

  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  opnd_state_t       state;
  opnd_state_t       state_nxt;
  logic              issue_err_nxt;

  regfile_core #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in),
    .readnum_a (readnum_a),
    .readnum_b (readnum_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      aout      <= '0;
      bout      <= '0;
      shift_out <= SH_NONE;
      state     <= EMPTY;
      issue_err <= 1'b0;
    end else begin
      if (loada) aout <= rdata_a;
      if (loadb) begin
        bout      <= rdata_b;
        shift_out <= shift_in;
      end
      state     <= state_nxt;
      issue_err <= issue_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    issue_err_nxt = issue && (state != READY);
    case (state)
      EMPTY: begin
        if (loada && loadb) state_nxt = READY;
        else if (loada)     state_nxt = HAVE_A;
        else if (loadb)     state_nxt = HAVE_B;
      end
      HAVE_A: if (loadb) state_nxt = READY;
      HAVE_B: if (loada) state_nxt = READY;
      READY: begin
        // Fresh loads take priority over the pair being consumed.
        if (issue) begin
          if (loada && loadb) state_nxt = READY;
          else if (loada)     state_nxt = HAVE_A;
          else if (loadb)     state_nxt = HAVE_B;
          else                state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign opnd_rdy = (state == READY);

endmodule

// File: doc/operand_regfile.md
Name: operand_regfile

Overview:
- Operand stage directly upstream of the datapath shifter.
- Holds an 8 x 16-bit register file with one synchronous write port.
- Latches operand A, and operand B together with its 2-bit shift code, into pipeline registers.
- Tracks operand readiness with a small state machine. bout/shift_out drive the shifter's in/shift inputs; aout goes to the ALU A input.

Parameters:
- DATA_W, 16, register and operand width.
- NREGS, 8, number of general registers.
- REG_AW, 3, register index width (log2 NREGS).

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- write  input  1  register-file write enable.
- writenum  input  REG_AW  write register index.
- data_in  input  DATA_W  write data.
- readnum_a  input  REG_AW  source index for operand A.
- readnum_b  input  REG_AW  source index for operand B.
- loada  input  1  capture regs[readnum_a] into aout.
- loadb  input  1  capture regs[readnum_b] into bout, and shift_in into shift_out.
- shift_in  input  2  shift code accompanying B: 00 pass, 01 LSL1, 10 LSR1, 11 ASR1.
- issue  input  1  downstream consumes the operand pair.
- aout  output  DATA_W  registered operand A.
- bout  output  DATA_W  registered operand B (to shifter in).
- shift_out  output  2  registered shift code (to shifter shift).
- opnd_rdy  output  1  both operands captured since last issue.
- issue_err  output  1  one-cycle pulse: issue while not ready.

Behaviour:
- Reset (synchronous, active-high; only clk edges matter):
  - All NREGS registers clear to 0.
  - aout = 0, bout = 0, shift_out = 2'b00, opnd_rdy = 0, issue_err = 0.
  - State goes to EMPTY.
  - Reset asserted mid-operation overrides write, loads and issue in that cycle.
- Write: at posedge with write=1, regs[writenum] <= data_in. Visible to loads from the next cycle.
- Loads:
  - At posedge, loada=1 sets aout <= regs[readnum_a]; loadb=1 sets bout <= regs[readnum_b] and shift_out <= shift_in.
  - Outputs hold otherwise. Latency is one cycle from load to output.
  - A and B may read the same index in the same cycle.
- Same-cycle write/load hazard (write=1, load of the same index): loaded value is the pre-write contents unless BYPASS_EN is defined.
- State machine (opnd_rdy = state==READY), evaluated on each posedge:
  - EMPTY: loada only -> HAVE_A; loadb only -> HAVE_B; both -> READY.
  - HAVE_A: loadb -> READY; loada re-captures and stays in HAVE_A.
  - HAVE_B: loada -> READY; loadb re-captures and stays in HAVE_B.
  - READY with issue=1:
    - No loads -> EMPTY.
    - loada only -> HAVE_A; loadb only -> HAVE_B; both -> READY.
    - New loads always win over consumption.
  - READY with issue=0: loads re-capture, stay in READY.
- issue while state != READY: ignored (state unchanged apart from any loads); issue_err=1 for exactly the next cycle.
- aout/bout are not cleared on issue; only the state changes.
- All arithmetic is width-exact; no sign extension in this block.

Optional Feature:
- Macro: OPERAND_REGFILE_BYPASS_EN.
- Defined: write=1 and a load of index == writenum in the same cycle captures data_in (write-through forwarding). Applies independently to A and B.
- Undefined: the load captures the old register value, and the new value is visible from the next cycle.

Decomposition:
- Shared package holds:
  - DATA_W, REG_AW, NREGS.
  - Shift-code constants SH_NONE=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11 (shared with the shifter and decoder).
  - Operand-state enum {EMPTY, HAVE_A, HAVE_B, READY}.
- One sub-module: regfile_core, containing the register array, synchronous write, and two combinational read ports with optional bypass mux.
- Operand latches and FSM stay in operand_regfile.

Test Plan:
- Reset then idle 3 cycles -> aout=0, bout=0, shift_out=00, opnd_rdy=0, issue_err=0. Loading any index returns 0x0000.
- Write R3=0x8001, next cycle loada(3) and loadb(3) with shift_in=11 -> after one cycle aout=bout=0x8001, shift_out=11, opnd_rdy=1.
- Sequence loada (HAVE_A), loada again, then loadb -> opnd_rdy rises only after loadb. Then issue -> opnd_rdy=0 next cycle, aout/bout unchanged.
- issue in EMPTY -> issue_err high exactly one cycle, state stays EMPTY. Then issue with simultaneous loada in READY -> HAVE_A, opnd_rdy=0.
- R5=0x1234, same cycle write R5=0xABCD and loadb(5):
  - Without macro: bout=0x1234.
  - With OPERAND_REGFILE_BYPASS_EN: bout=0xABCD.
  - Either way a later loadb(5) gives 0xABCD.
- Reset asserted in READY together with write R1=0xFFFF and loada -> all outputs 0, state EMPTY, R1 reads 0.
